// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default constants for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } pctrl_state_t;

  localparam int unsigned FLUSH_CYCLES_DEF = 2;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned MEM_TIMEOUT_DEF  = 64;
  localparam int unsigned CNT_W_DEF        = 16;

  // Phase counters hold values up to 7; wait counter spans the timeout range.
  localparam int unsigned PH_CNT_W = 3;
  localparam int unsigned WAIT_W   = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: stalls, branch flushes, memory wait-states,
// halt with drain, and a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  pctrl_state_t        state_q, state_d;
  logic [PH_CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic [PH_CNT_W-1:0] dr_cnt_q, dr_cnt_d;
  logic                halt_pending_q, halt_pending_d;
  logic                mem_err_q, mem_err_d;
  logic [WAIT_W-1:0]   wait_cnt;

  logic freeze_c;
  logic stall_inc_c;
  logic pc_en_c, en_if_id_c, en_id_ex_c, en_ex_mem_c, en_mem_wb_c;
  logic flush_if_id_c, flush_id_ex_c;

  assign freeze_c    = mem_req & ~mem_ack & (state_q != ST_HALTED);
  assign stall_inc_c = (state_q != ST_HALTED) & ~pc_en_c;

  // State, phase counters and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      fl_cnt_q       <= '0;
      dr_cnt_q       <= '0;
      halt_pending_q <= 1'b0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      fl_cnt_q       <= fl_cnt_d;
      dr_cnt_q       <= dr_cnt_d;
      halt_pending_q <= halt_pending_d;
      mem_err_q      <= mem_err_d;
    end
  end

  // Next-state and combinational stage controls.
  always_comb begin
    state_d        = state_q;
    fl_cnt_d       = fl_cnt_q;
    dr_cnt_d       = dr_cnt_q;
    halt_pending_d = halt_pending_q;
    mem_err_d      = mem_err_q;
    pc_en_c        = 1'b0;
    en_if_id_c     = 1'b0;
    en_id_ex_c     = 1'b0;
    en_ex_mem_c    = 1'b0;
    en_mem_wb_c    = 1'b0;
    flush_if_id_c  = 1'b0;
    flush_id_ex_c  = 1'b0;

    if (freeze_c && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))) begin
      mem_err_d = 1'b1;
    end

    unique case (state_q)
      ST_RUN: begin
        if (!freeze_c) begin
          if (branch_taken) begin
            pc_en_c        = 1'b1;
            en_if_id_c     = 1'b1;
            en_id_ex_c     = 1'b1;
            en_ex_mem_c    = 1'b1;
            en_mem_wb_c    = 1'b1;
            flush_if_id_c  = 1'b1;
            flush_id_ex_c  = 1'b1;
            halt_pending_d = halt_pending_q | halt_req;
            if (FLUSH_CYCLES > 1) begin
              state_d  = ST_FLUSH;
              fl_cnt_d = PH_CNT_W'(FLUSH_CYCLES - 1);
            end
          end else if (load_use_hazard) begin
            en_id_ex_c     = 1'b1;
            en_ex_mem_c    = 1'b1;
            en_mem_wb_c    = 1'b1;
            flush_id_ex_c  = 1'b1;
            halt_pending_d = halt_pending_q | halt_req;
          end else begin
            pc_en_c     = 1'b1;
            en_if_id_c  = 1'b1;
            en_id_ex_c  = 1'b1;
            en_ex_mem_c = 1'b1;
            en_mem_wb_c = 1'b1;
            if (halt_req || halt_pending_q) begin
              state_d        = ST_DRAIN;
              dr_cnt_d       = PH_CNT_W'(DRAIN_CYCLES);
              halt_pending_d = 1'b0;
            end
          end
        end
      end

      ST_FLUSH: begin
        if (!freeze_c) begin
          pc_en_c       = 1'b1;
          en_if_id_c    = 1'b1;
          en_id_ex_c    = 1'b1;
          en_ex_mem_c   = 1'b1;
          en_mem_wb_c   = 1'b1;
          flush_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
          if (halt_req) begin
            halt_pending_d = 1'b1;
          end
          // A fresh branch restarts the flush window from this cycle.
          if (branch_taken) begin
            fl_cnt_d = PH_CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            fl_cnt_d = fl_cnt_q - PH_CNT_W'(1);
            if (fl_cnt_q == PH_CNT_W'(1)) begin
              state_d = ST_RUN;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (!freeze_c) begin
          en_if_id_c    = 1'b1;
          en_id_ex_c    = 1'b1;
          en_ex_mem_c   = 1'b1;
          en_mem_wb_c   = 1'b1;
          flush_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
          dr_cnt_d      = dr_cnt_q - PH_CNT_W'(1);
          if (dr_cnt_q == PH_CNT_W'(1)) begin
            state_d = ST_HALTED;
          end
        end
      end

      ST_HALTED: begin
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // A latched memory timeout parks the core one cycle after it is flagged.
    if (mem_err_q && (state_q != ST_HALTED)) begin
      state_d = ST_HALTED;
    end
  end

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (freeze_c),
    .clr   (~freeze_c),
    .count (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (stall_inc_c),
    .clr   (1'b0),
    .count (stall_cycles)
  );

  assign pc_en       = reset & pc_en_c;
  assign en_if_id    = reset & en_if_id_c;
  assign en_id_ex    = reset & en_id_ex_c;
  assign en_ex_mem   = reset & en_ex_mem_c;
  assign en_mem_wb   = reset & en_mem_wb_c;
  assign flush_if_id = reset & flush_if_id_c;
  assign flush_id_ex = reset & flush_id_ex_c;
  assign halted      = reset & (state_q == ST_HALTED);
  assign mem_err     = reset & mem_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized bench for pipeline_ctrl against a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int DRAIN_CYCLES = 3;
  localparam int MEM_TIMEOUT  = 6;
  localparam int CNT_W        = 6;
  localparam int STALL_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_use_hazard = 1'b0, branch_taken = 1'b0, halt_req = 1'b0;
  logic mem_req = 1'b0, mem_ack = 1'b0;
  logic pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic flush_if_id, flush_id_ex, halted, mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [8:0] obs;

  pipeline_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_use_hazard(load_use_hazard),
    .branch_taken   (branch_taken),
    .halt_req       (halt_req),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .pc_en          (pc_en),
    .en_if_id       (en_if_id),
    .en_id_ex       (en_id_ex),
    .en_ex_mem      (en_ex_mem),
    .en_mem_wb      (en_mem_wb),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .halted         (halted),
    .mem_err        (mem_err),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  assign obs = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                flush_if_id, flush_id_ex, halted, mem_err};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining flush/drain cycles, flags, counters.
  bit m_halted, m_pending, m_err;
  int m_flush_rem, m_drain_rem, m_wait, m_stall;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_pending = 0; m_err = 0;
    m_flush_rem = 0; m_drain_rem = 0; m_wait = 0; m_stall = 0;
  endtask

  task automatic step(input bit rst_v, input bit lu_v, input bit br_v,
                      input bit hr_v, input bit mr_v, input bit ma_v,
                      input string tag);
    bit frz, err_set, go_halt;
    bit pc, ifid, idex, exmem, memwb, fif, fid;
    int exp_o, exp_s;
    @(posedge clk);
    #1;
    reset = rst_v; load_use_hazard = lu_v; branch_taken = br_v;
    halt_req = hr_v; mem_req = mr_v; mem_ack = ma_v;
    @(negedge clk);
    if (!rst_v) begin
      model_reset();
      check_eq({tag, "/outs"}, int'(obs), 0);
      check_eq({tag, "/stall"}, int'(stall_cycles), 0);
    end else begin
      frz = mr_v && !ma_v && !m_halted;
      {pc, ifid, idex, exmem, memwb, fif, fid} = '0;
      if (m_halted || frz) begin
      end else if (m_drain_rem > 0) begin
        {ifid, idex, exmem, memwb, fif, fid} = '1;
      end else if (m_flush_rem > 0 || br_v) begin
        {pc, ifid, idex, exmem, memwb, fif, fid} = '1;
      end else if (lu_v) begin
        {idex, exmem, memwb, fid} = '1;
      end else begin
        {pc, ifid, idex, exmem, memwb} = '1;
      end
      exp_o = int'({pc, ifid, idex, exmem, memwb, fif, fid, m_halted, m_err});
      exp_s = m_stall;
      check_eq({tag, "/outs"}, int'(obs), exp_o);
      check_eq({tag, "/stall"}, int'(stall_cycles), exp_s);

      if (!m_halted && !pc) m_stall = (m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX;
      err_set = frz && (m_wait == MEM_TIMEOUT - 1);
      go_halt = m_err && !m_halted;
      m_wait  = frz ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
      if (!m_halted && !frz) begin
        if (m_drain_rem > 0) begin
          m_drain_rem--;
          if (m_drain_rem == 0) m_halted = 1;
        end else if (m_flush_rem > 0) begin
          if (hr_v) m_pending = 1;
          m_flush_rem = br_v ? FLUSH_CYCLES - 1 : m_flush_rem - 1;
        end else if (br_v) begin
          m_flush_rem = FLUSH_CYCLES - 1;
          m_pending   = m_pending | hr_v;
        end else if (lu_v) begin
          m_pending = m_pending | hr_v;
        end else if (hr_v || m_pending) begin
          m_drain_rem = DRAIN_CYCLES;
          m_pending   = 0;
        end
      end
      if (go_halt) m_halted = 1;
      if (err_set) m_err = 1;
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic do_reset(input string tag);
    for (int i = 0; i < 3; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), tag);
  endtask

  initial begin
    model_reset();

    // Reset with random inputs, then quiet run.
    do_reset("rst");
    idle(2, "run_idle");

    // Two-cycle load-use stall.
    step(1, 1, 0, 0, 0, 0, "lu");
    step(1, 1, 0, 0, 0, 0, "lu");
    idle(1, "lu_after");
    check_eq("lu_stall_cnt", int'(stall_cycles), 2);

    // Branch; load-use in the flush cycle is ignored.
    step(1, 0, 1, 0, 0, 0, "br");
    step(1, 1, 0, 0, 0, 0, "br_flush_lu");
    check_eq("br_flush2", int'(flush_if_id), 1);
    idle(2, "br_after");

    // Branch then five frozen cycles inside the flush, then ack.
    do_reset("rst2");
    step(1, 0, 1, 0, 0, 0, "frz_br");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 0, "frz");
    step(1, 0, 0, 0, 1, 1, "frz_ack");
    check_eq("frz_flush_resumes", int'(flush_id_ex), 1);
    idle(2, "frz_after");
    check_eq("frz_stall_cnt", int'(stall_cycles), 5);
    check_eq("frz_no_err", int'(mem_err), 0);

    // Memory never acknowledges: timeout, then halt.
    do_reset("rst3");
    for (int i = 0; i < MEM_TIMEOUT; i++) step(1, 0, 0, 0, 1, 0, "tmo");
    step(1, 0, 0, 0, 1, 0, "tmo_err");
    check_eq("tmo_err_set", int'(mem_err), 1);
    check_eq("tmo_not_yet_halted", int'(halted), 0);
    step(1, 0, 0, 0, 1, 0, "tmo_halt");
    check_eq("tmo_halted", int'(halted), 1);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 1, "tmo_stay");
    check_eq("tmo_err_sticky", int'(mem_err), 1);

    // Halt pulse during a flush drains and halts.
    do_reset("rst4");
    step(1, 0, 1, 0, 0, 0, "hlt_br");
    step(1, 0, 0, 1, 0, 0, "hlt_req");
    idle(1 + DRAIN_CYCLES, "hlt_drain");
    idle(2, "hlt_done");
    check_eq("hlt_halted", int'(halted), 1);
    check_eq("hlt_pc_en", int'(pc_en), 0);

    // Stall counter saturation.
    do_reset("rst5");
    for (int i = 0; i < STALL_MAX + 8; i++) step(1, 1, 0, 0, 0, 0, "sat");
    idle(1, "sat_after");
    check_eq("sat_value", int'(stall_cycles), STALL_MAX);

    // Randomized episodes, including occasional async reset.
    for (int ep = 0; ep < 10; ep++) begin
      do_reset("rnd_rst");
      for (int c = 0; c < 50; c++) begin
        bit mr;
        mr = ($urandom_range(0, 99) < 30);
        step(($urandom_range(0, 99) >= 2),
             ($urandom_range(0, 99) < 25),
             ($urandom_range(0, 99) < 15),
             ($urandom_range(0, 99) < 6),
             mr,
             mr && ($urandom_range(0, 99) < 50),
             "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the pipelined CPU core. It owns the enable and flush inputs of the four pipeline-register banks and the PC register, all of which are built from `D_FF` cells with enable/clear muxing. It resolves load-use stalls, taken-branch flushes, memory wait-states and an orderly halt with drain, and provides a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- `FLUSH_CYCLES`, 2: cycles the front-end flushes are asserted per taken branch; legal range 1..7.
- `DRAIN_CYCLES`, 3: cycles spent draining EX/MEM/WB before halt; legal range 1..7.
- `MEM_TIMEOUT`, 64: consecutive memory-wait cycles that raise `mem_err`; legal range 2..255.
- `CNT_W`, 16: width of `stall_cycles`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `load_use_hazard`  in  1  ID-stage load-use detect.
- `branch_taken`  in  1  EX-stage taken-branch resolve.
- `halt_req`  in  1  halt request, level or pulse.
- `mem_req`  in  1  MEM stage has an access outstanding.
- `mem_ack`  in  1  memory completes the access this cycle.
- `pc_en`  out  1  PC register enable.
- `en_if_id`, `en_id_ex`, `en_ex_mem`, `en_mem_wb`  out  1 each  pipeline-register enables.
- `flush_if_id`, `flush_id_ex`  out  1 each  load a bubble on the next edge when the matching enable is 1.
- `halted`  out  1  core is in HALTED.
- `mem_err`  out  1  sticky memory-timeout error.
- `stall_cycles`  out  `CNT_W`  saturating count of stalled cycles.

## Operation
- States: RUN, FLUSH, DRAIN, HALTED (2-bit encoding). Registered state; outputs are combinational from state and current inputs, so stalls act in the cycle they are raised.
- freeze = `mem_req & ~mem_ack`, in RUN/FLUSH/DRAIN. It overrides everything: all enables 0, flushes 0, no state or counter advance other than `wait_cnt`/`stall_cycles`.
- RUN, no freeze, priority branch > load-use > halt:
  - `branch_taken`: all enables 1, both flushes 1. If `FLUSH_CYCLES`>1, go to FLUSH with `fl_cnt`=`FLUSH_CYCLES`-1.
  - `load_use_hazard`: `pc_en`=0, `en_if_id`=0, `flush_id_ex`=1, other enables 1.
  - `halt_req` or `halt_pending`: go to DRAIN with `dr_cnt`=`DRAIN_CYCLES`, clear `halt_pending`.
  - Otherwise: all enables 1, flushes 0.
- FLUSH: all enables 1, both flushes 1, `load_use_hazard` ignored. `fl_cnt` decrements and the block returns to RUN when it reaches 0. A new `branch_taken` reloads `fl_cnt`=`FLUSH_CYCLES`-1. `halt_req` sets sticky `halt_pending`.
- DRAIN: `pc_en`=0, both flushes 1, all register enables 1. `dr_cnt` decrements and the block goes to HALTED when it reaches 0.
- HALTED: all enables 0, flushes 0, `halted`=1. Only reset exits this state.
- `wait_cnt` (8 bit) increments while freeze is active and clears otherwise. When freeze is active with `wait_cnt`=`MEM_TIMEOUT`-1, set `mem_err` and go to HALTED next cycle.
- `stall_cycles` increments in every non-HALTED cycle with `pc_en`=0 and saturates at all-ones.

## Timing
- While `reset`=0, asynchronously: state=RUN, all counters 0, `halt_pending`=0, `mem_err`=0, `halted`=0, and every enable and flush is forced to 0.
- First rising edge after reset release: normal RUN behaviour.
- Load-use stall lasts exactly the cycles in which `load_use_hazard`=1, with zero added latency.
- Branch: flushes are high for `FLUSH_CYCLES` consecutive unfrozen cycles, counting the resolve cycle.
- Halt: from `halt_req` sampled in RUN, `halted`=1 after `DRAIN_CYCLES`+1 edges, plus any frozen cycles.
- `mem_ack` in the same cycle as `mem_req` means no freeze.
- Reset asserted mid-FLUSH, DRAIN or freeze aborts the operation immediately.

## Structure
- Package `pipeline_ctrl_pkg` holds the state enum `pctrl_state_t` and default parameter constants.
- Sub-module `sat_counter` (parameter `W`, inputs `inc`/`clr`, asynchronous active-low reset) is used for `stall_cycles`. `wait_cnt` reuses the same sub-module.

## Test plan
- Reset held low 3 cycles with random inputs: all outputs 0. After release with no requests: all enables 1, flushes 0.
- `load_use_hazard` for 2 cycles: `pc_en`=`en_if_id`=0 and `flush_id_ex`=1 for exactly those 2 cycles; `stall_cycles`=2.
- `branch_taken` 1 cycle, `FLUSH_CYCLES`=2: flushes high for 2 cycles. `load_use_hazard` asserted in the second cycle is ignored.
- `mem_req`=1, `mem_ack`=0 for 5 cycles during FLUSH: all enables 0 for 5 cycles, `fl_cnt` holds, the flush completes after `mem_ack`; `stall_cycles`=5.
- `mem_req`=1, `mem_ack` never asserted, `MEM_TIMEOUT`=4: `mem_err`=1 on the 4th edge, `halted`=1 on the next edge, and both stay set until reset.
- `halt_req` pulse during FLUSH: after the flush ends, DRAIN runs 3 cycles with `pc_en`=0, then `halted`=1 with all enables 0.
